// File: rtl/fetch_issue_unit.sv
// Instruction fetch front end: fetches from imem over req/ack, buffers two
// instructions and issues them to decode; applies execute-stage redirects.
//
// state | meaning
// BOOT  | first cycle after reset release, no request yet
// FETCH | normal fetching from PC, enqueue on ack
// DRAIN | abandoned request still pending, its data is discarded on ack
module fetch_issue_unit #(
    parameter int              ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     NOP_INST = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              inst_valid,
    output logic [15:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              id_ready,
    input  logic              ex_valid,
    input  logic [1:0]        ex_br_sel,
    input  logic              ex_brx,
    input  logic              ex_lr_en,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              z_flag,
    input  logic              n_flag,
    output logic [ADDR_W-1:0] lr
);

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] lr_q, lr_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       inst_mem_q [2];
    logic [15:0]       inst_mem_d [2];
    logic [ADDR_W-1:0] pc_mem_q [2];
    logic [ADDR_W-1:0] pc_mem_d [2];
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        count_q, count_d;

    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              pending;
    logic              enq;
    logic              deq;

    always_comb begin
        taken   = ex_valid && ((ex_br_sel == 2'b01) || (ex_br_sel == 2'b11) ||
                  ((ex_br_sel == 2'b10) && (ex_brx ? n_flag : z_flag)));
        target  = (ex_br_sel == 2'b11) ? lr_q : ex_target;
        pending = req_q && !imem_ack;
        enq     = (state_q == ST_FETCH) && req_q && imem_ack;
        deq     = (count_q != 2'd0) && id_ready;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        lr_d       = lr_q;
        req_d      = req_q;
        addr_d     = addr_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;

        if (taken && ex_lr_en)
            lr_d = ex_pc + PC_ONE;

        if (taken) begin
            // Flush wins over any enqueue or dequeue this cycle.
            pc_d    = target;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            count_d = 2'd0;
            if (pending) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = target;
            end
        end else begin
            if (enq) begin
                inst_mem_d[wr_q] = imem_rdata;
                pc_mem_d[wr_q]   = pc_q;
                wr_d             = ~wr_q;
                pc_d             = pc_q + PC_ONE;
            end
            if (deq)
                rd_d = ~rd_q;
            case ({enq, deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase

            case (state_q)
                ST_BOOT: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                ST_FETCH: begin
                    // Only one request in flight; raise the next only if it has room.
                    if (!pending) begin
                        req_d  = (count_d < 2'd2);
                        addr_d = pc_d;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            lr_q    <= '0;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            lr_q       <= lr_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            count_q    <= count_d;
            inst_mem_q <= inst_mem_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

    always_comb begin
        imem_req   = req_q;
        imem_addr  = addr_q;
        lr         = lr_q;
        inst_valid = (count_q != 2'd0);
        inst       = inst_valid ? inst_mem_q[rd_q] : NOP_INST;
        inst_pc    = inst_valid ? pc_mem_q[rd_q] : '0;
    end

endmodule
